decimal_key_scheduler: RTL

Round-robin scheduler for a 10-line decimal keypad. It feeds the one-hot decimal encoder and emits one BCD digit per key press over a valid/ready handshake. It arbitrates simultaneous presses fairly, holds the winning one-hot grant stable until the consumer accepts the digit, and re-arms only after the winning key is released. It sits between raw key inputs and any digit consumer, such as a display or accumulator.

---
 rtl/decimal_key_pkg.sv | 24 ++
 rtl/encoder_decimaltoBCD.sv | 20 ++
 rtl/decimal_key_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/decimal_key_pkg.sv
// Shared types and helpers for the decimal keypad scheduler.
// Digit count, BCD width, FSM states and round-robin index step.
package decimal_key_pkg;

    localparam int NUM_DIGITS = 10;
    localparam int BCD_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        OUT,
        RELEASE
    } state_e;

    // Step a digit index upward, wrapping 9 back to 0.
    function automatic logic [BCD_W-1:0] rr_next(
        input logic [BCD_W-1:0] idx
    );
        if (idx == BCD_W'(NUM_DIGITS - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/encoder_decimaltoBCD.sv
// One-hot decimal to BCD encoder.
// An all-zero input encodes as 0.
module encoder_decimaltoBCD
    import decimal_key_pkg::*;
(
    input  logic [NUM_DIGITS-1:0] dec_in,
    output logic [BCD_W-1:0]      bcd_out
);

    // OR together the indices of the set bits; one-hot input gives one index.
    always_comb begin
        bcd_out = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dec_in[i]) begin
                bcd_out = bcd_out | BCD_W'(i);
            end
        end
    end

endmodule

// File: rtl/decimal_key_scheduler.sv
// Round-robin keypad scheduler emitting one BCD digit per key press.
// Optional input debounce is enabled with DECIMAL_KEY_DEBOUNCE_EN.
module decimal_key_scheduler
    import decimal_key_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] req,
    input  logic       bcd_ready,
    output logic       bcd_valid,
    output logic [3:0] bcd_out,
    output logic [9:0] grant,
    output logic       busy
);

    logic [NUM_DIGITS-1:0] freq;

    state_e                state_q, state_d;
    logic [BCD_W-1:0]      ptr_q, ptr_d;
    logic [BCD_W-1:0]      win_q, win_d;
    logic [NUM_DIGITS-1:0] grant_q, grant_d;

    logic [BCD_W-1:0]      pick;
    logic [BCD_W-1:0]      idx;
    logic                  found;

`ifdef DECIMAL_KEY_DEBOUNCE_EN
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_deb
        logic       s1_q, s1_d;
        logic       s2_q, s2_d;
        logic       filt_q, filt_d;
        logic [7:0] cnt_q, cnt_d;

        // Synchronize, then flip the filtered level after a stable run.
        always_comb begin
            s1_d   = req[i];
            s2_d   = s1_q;
            filt_d = filt_q;
            cnt_d  = '0;
            if (s2_q != filt_q) begin
                if (cnt_q + 8'd1 >= 8'(DEB_CYCLES)) begin
                    filt_d = s2_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end

        // Debounce state registers.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_q   <= 1'b0;
                s2_q   <= 1'b0;
                filt_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                s1_q   <= s1_d;
                s2_q   <= s2_d;
                filt_q <= filt_d;
                cnt_q  <= cnt_d;
            end
        end

        assign freq[i] = filt_q;
    end
`else
    logic [7:0] unused_deb_cycles;
    assign unused_deb_cycles = 8'(DEB_CYCLES);
    assign freq = req;
`endif

    // Find the first pending key at or above ptr, wrapping past 9.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!found && freq[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = rr_next(idx);
        end
    end

    // Grant, handshake and release sequencing.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (|freq) begin
                    win_d   = pick;
                    grant_d = NUM_DIGITS'(1) << pick;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bcd_ready) begin
                    ptr_d   = rr_next(win_q);
                    grant_d = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!freq[win_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
        end
    end

    encoder_decimaltoBCD u_enc (
        .dec_in  (grant_q),
        .bcd_out (bcd_out)
    );

    assign grant     = grant_q;
    assign bcd_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);

endmodule
